// File: rtl/m_fetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches, buffers the
// returned words with their PCs and hands them to decode in order. A redirect
// flushes buffered words and marks in-flight responses for discard.
module m_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = CW + 2;

   // registered state
   logic [31:0]   fetch_pc;
   logic [31:0]   q_pc   [DEPTH];
   logic [31:0]   q_data [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop;
   logic [31:0]   pf_pc  [DEPTH];
   logic [PW-1:0] pf_rd;
   logic [PW-1:0] pf_wr;

   // next-state values
   logic [31:0]   fetch_pc_n;
   logic [PW-1:0] rd_ptr_n;
   logic [PW-1:0] wr_ptr_n;
   logic [CW-1:0] count_n;
   logic [CW-1:0] outstanding_n;
   logic [CW-1:0] drop_n;
   logic [PW-1:0] pf_rd_n;
   logic [PW-1:0] pf_wr_n;

   // per-cycle events
   logic [SW-1:0] occupancy;
   logic          credit_ok;
   logic          req_fire;
   logic          rsp_keep;
   logic          rsp_drop;
   logic          pop;

   // credit, handshakes and head-of-queue outputs
   always_comb begin
      occupancy     = {2'b00, count} + {2'b00, outstanding} + {2'b00, drop};
      credit_ok     = (occupancy < SW'(DEPTH));
      mem_req_valid = !rst && !redirect_valid && credit_ok;
      mem_req_addr  = fetch_pc;
      req_fire      = mem_req_valid && mem_req_ready;
      rsp_keep      = mem_rsp_valid && !redirect_valid && (drop == '0);
      rsp_drop      = mem_rsp_valid && !redirect_valid && (drop != '0);
      instr_valid   = (count != '0);
      pop           = instr_valid && instr_ready;
      instruction   = q_data[rd_ptr];
      instr_pc      = q_pc[rd_ptr];
   end

   // next-state for fetch address, queue pointers and the three counters
   always_comb begin
      fetch_pc_n    = fetch_pc;
      rd_ptr_n      = rd_ptr;
      wr_ptr_n      = wr_ptr;
      count_n       = count;
      outstanding_n = outstanding;
      drop_n        = drop;
      pf_rd_n       = pf_rd;
      pf_wr_n       = pf_wr;

      if (redirect_valid) begin
         // Everything in flight becomes discardable; a response landing in
         // this very cycle is already gone, so it is not counted again.
         fetch_pc_n    = redirect_pc & 32'hFFFF_FFFC;
         rd_ptr_n      = '0;
         wr_ptr_n      = '0;
         count_n       = '0;
         outstanding_n = '0;
         pf_rd_n       = '0;
         pf_wr_n       = '0;
         if (mem_rsp_valid && ((drop != '0) || (outstanding != '0)))
            drop_n = drop + outstanding - CW'(1);
         else
            drop_n = drop + outstanding;
      end else begin
         if (req_fire) begin
            fetch_pc_n = fetch_pc + 32'd4;
            pf_wr_n    = pf_wr + PW'(1);
         end
         if (rsp_keep) begin
            wr_ptr_n = wr_ptr + PW'(1);
            pf_rd_n  = pf_rd + PW'(1);
         end
         if (pop)
            rd_ptr_n = rd_ptr + PW'(1);

         if (rsp_keep && !pop)
            count_n = count + CW'(1);
         else if (!rsp_keep && pop)
            count_n = count - CW'(1);

         if (req_fire && !rsp_keep)
            outstanding_n = outstanding + CW'(1);
         else if (!req_fire && rsp_keep)
            outstanding_n = outstanding - CW'(1);

         if (rsp_drop)
            drop_n = drop - CW'(1);
      end
   end

   // control state register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= '0;
         drop        <= '0;
         pf_rd       <= '0;
         pf_wr       <= '0;
      end else begin
         fetch_pc    <= fetch_pc_n;
         rd_ptr      <= rd_ptr_n;
         wr_ptr      <= wr_ptr_n;
         count       <= count_n;
         outstanding <= outstanding_n;
         drop        <= drop_n;
         pf_rd       <= pf_rd_n;
         pf_wr       <= pf_wr_n;
      end
   end

   // queue storage; cleared on reset so the head reads as zero until filled
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            q_pc[i]   <= '0;
            q_data[i] <= '0;
         end
      end else if (rsp_keep) begin
         q_pc[wr_ptr]   <= pf_pc[pf_rd];
         q_data[wr_ptr] <= mem_rsp_data;
      end
   end

   // PCs of kept in-flight requests, oldest first
   always_ff @(posedge clk) begin
      if (req_fire)
         pf_pc[pf_wr] <= fetch_pc;
   end

endmodule

// File: tb/tb_m_fetch_queue.sv
// Directed and lightly randomised bench for m_fetch_queue with a
// variable-latency memory model and a decode-side event log.
module tb_m_fetch_queue;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b1;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data  = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc    = 32'h0;
   logic [31:0] instruction;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;

   m_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instruction    (instruction),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   typedef struct { logic [31:0] addr; int due; } req_t;
   typedef struct { bit redir; logic [31:0] pc; logic [31:0] data; } ev_t;
   req_t pend[$];
   ev_t  evq[$];
   int   cyc_n    = 0;
   int   acc_cnt  = 0;
   int   lat      = 1;
   bit   rnd_mode = 1'b0;

   // memory model: inputs change at negedge, model acts at +1/+2, bench checks at +3
   always begin
      @(negedge clk);
      #1;
      cyc_n++;
      if (rst) begin
         pend.delete();
         acc_cnt       = 0;
         mem_rsp_valid = 1'b0;
         mem_rsp_data  = 32'h0;
      end else begin
         mem_req_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (pend.size() > 0 && pend[0].due <= cyc_n) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mdata(pend[0].addr);
         end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'h0;
         end
      end
      #1;
      if (!rst) begin
         if (mem_rsp_valid)
            void'(pend.pop_front());
         if (mem_req_valid && mem_req_ready) begin
            pend.push_back('{addr: mem_req_addr,
                             due: cyc_n + (rnd_mode ? int'($urandom_range(1, 3)) : lat)});
            acc_cnt++;
         end
      end
   end

   // decode-side log: consumed words, then any redirect of the same cycle
   always begin
      @(negedge clk);
      #4;
      if (!rst) begin
         if (instr_valid && instr_ready)
            evq.push_back('{redir: 1'b0, pc: instr_pc, data: instruction});
         if (redirect_valid)
            evq.push_back('{redir: 1'b1, pc: redirect_pc, data: 32'h0});
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input int idx, input logic [31:0] pc);
      checks++;
      assert (idx < evq.size()) else begin
         errors++;
         $error("FAIL %s observed log size %0d expected entry %0d", tag, evq.size(), idx);
      end
      if (idx < evq.size()) begin
         chk({tag, "_kind"}, 32'(evq[idx].redir), 32'h0);
         chk({tag, "_pc"}, evq[idx].pc, pc);
         chk({tag, "_data"}, evq[idx].data, mdata(pc));
      end
   endtask

   task automatic next_cyc();
      @(negedge clk);
      #3;
   endtask

   // holds reset for three cycles, returns at +3 of the first cycle after
   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      redirect_valid = 1'b0;
      repeat (2) @(negedge clk);
      #3;
      chk("rst_instr_valid", 32'(instr_valid), 32'h0);
      chk("rst_req_valid", 32'(mem_req_valid), 32'h0);
      chk("rst_req_addr", mem_req_addr, 32'h0);
      chk("rst_instruction", instruction, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      evq.delete();
      #3;
   endtask

   initial begin
      int          first;
      int          nwords;
      logic [31:0] exp_pc;

      // 1: streaming, latency 1, decoder always ready
      lat = 1;
      instr_ready = 1'b1;
      reset_dut();
      chk("c0_instr_valid", 32'(instr_valid), 32'h0);
      chk("c0_instruction", instruction, 32'h0);
      chk("c0_instr_pc", instr_pc, 32'h0);
      for (int k = 0; k < 10; k++) begin
         if (k > 0) next_cyc();
         chk("stream_req_valid", 32'(mem_req_valid), 32'h1);
         chk("stream_req_addr", mem_req_addr, 32'(4 * k));
         if (k >= 2) begin
            chk("stream_instr_valid", 32'(instr_valid), 32'h1);
            chk("stream_instr_pc", instr_pc, 32'(4 * (k - 2)));
            chk("stream_instruction", instruction, mdata(32'(4 * (k - 2))));
         end else begin
            chk("stream_early_valid", 32'(instr_valid), 32'h0);
         end
      end

      // 2: decoder stalled until the credit is exhausted, then drains in order
      instr_ready = 1'b0;
      reset_dut();
      repeat (19) next_cyc();
      chk("bp_accepts", 32'(acc_cnt), 32'd4);
      chk("bp_count", 32'(dut.count), 32'd4);
      chk("bp_req_valid", 32'(mem_req_valid), 32'h0);
      chk("bp_instr_valid", 32'(instr_valid), 32'h1);
      chk("bp_head_pc", instr_pc, 32'h0);
      @(negedge clk);
      instr_ready = 1'b1;
      #3;
      repeat (10) next_cyc();
      for (int i = 0; i < 5; i++)
         chk_word("bp_drain", i, 32'(4 * i));

      // 3: redirect with two requests in flight
      lat = 3;
      instr_ready = 1'b1;
      reset_dut();
      next_cyc();
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      #3;
      chk("r3_no_req", 32'(mem_req_valid), 32'h0);
      chk("r3_outstanding", 32'(dut.outstanding), 32'd2);
      @(negedge clk);
      redirect_valid = 1'b0;
      #3;
      chk("r3_req_valid", 32'(mem_req_valid), 32'h1);
      chk("r3_req_addr", mem_req_addr, 32'h100);
      chk("r3_instr_valid", 32'(instr_valid), 32'h0);
      chk("r3_drop", 32'(dut.drop), 32'd2);
      chk("r3_outstanding_clr", 32'(dut.outstanding), 32'd0);
      repeat (10) next_cyc();
      chk("r3_marker", 32'(evq.size() > 0 && evq[0].redir), 32'h1);
      chk_word("r3_first", 1, 32'h100);
      chk_word("r3_second", 2, 32'h104);

      // 4: redirect together with a response and a decode handshake
      lat = 2;
      reset_dut();
      next_cyc();
      next_cyc();
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      #3;
      chk("r4_instr_valid", 32'(instr_valid), 32'h1);
      chk("r4_head_pc", instr_pc, 32'h0);
      chk("r4_rsp_valid", 32'(mem_rsp_valid), 32'h1);
      chk("r4_outstanding", 32'(dut.outstanding), 32'd2);
      @(negedge clk);
      redirect_valid = 1'b0;
      #3;
      chk("r4_drop", 32'(dut.drop), 32'd1);
      chk("r4_outstanding_clr", 32'(dut.outstanding), 32'd0);
      chk("r4_instr_valid_clr", 32'(instr_valid), 32'h0);
      chk("r4_req_addr", mem_req_addr, 32'h200);
      chk("r4_req_valid", 32'(mem_req_valid), 32'h1);
      repeat (8) next_cyc();
      chk_word("r4_consumed", 0, 32'h0);
      chk("r4_marker", 32'(evq.size() > 1 && evq[1].redir), 32'h1);
      chk_word("r4_restart", 2, 32'h200);

      // 5: address wrap, unaligned redirect, back-to-back redirects
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      #3;
      chk("wrap_no_req", 32'(mem_req_valid), 32'h0);
      @(negedge clk);
      redirect_valid = 1'b0;
      #3;
      chk("wrap_req_valid", 32'(mem_req_valid), 32'h1);
      chk("wrap_addr_hi", mem_req_addr, 32'hFFFF_FFFC);
      next_cyc();
      chk("wrap_addr_lo", mem_req_addr, 32'h0);
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'h103;
      #3;
      @(negedge clk);
      redirect_valid = 1'b0;
      #3;
      chk("unaligned_addr", mem_req_addr, 32'h100);
      @(negedge clk);
      evq.delete();
      redirect_valid = 1'b1;
      redirect_pc = 32'h300;
      #3;
      @(negedge clk);
      redirect_pc = 32'h400;
      #3;
      chk("b2b_no_req", 32'(mem_req_valid), 32'h0);
      @(negedge clk);
      redirect_valid = 1'b0;
      #3;
      chk("b2b_addr", mem_req_addr, 32'h400);
      repeat (10) next_cyc();
      first = -1;
      for (int i = 0; i < evq.size(); i++)
         if (first < 0 && !evq[i].redir) first = i;
      chk_word("b2b_first", first < 0 ? evq.size() : first, 32'h400);

      // 6: random ready/latency/redirects, scoreboard afterwards
      rnd_mode = 1'b1;
      reset_dut();
      for (int n = 0; n < 800; n++) begin
         @(negedge clk);
         instr_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 29) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc = $urandom;
         end else begin
            redirect_valid = 1'b0;
         end
         #3;
         chk("rnd_credit",
             32'((32'(dut.count) + 32'(dut.outstanding) + 32'(dut.drop)) <= DEPTH), 32'h1);
      end
      @(negedge clk);
      redirect_valid = 1'b0;
      instr_ready = 1'b1;
      #3;
      repeat (30) next_cyc();
      exp_pc = 32'h0;
      nwords = 0;
      for (int i = 0; i < evq.size(); i++) begin
         if (evq[i].redir) begin
            exp_pc = evq[i].pc & 32'hFFFF_FFFC;
         end else begin
            chk("rnd_pc", evq[i].pc, exp_pc);
            chk("rnd_data", evq[i].data, mdata(evq[i].pc));
            exp_pc = exp_pc + 32'd4;
            nwords++;
         end
      end
      chk("rnd_enough_words", 32'(nwords > 50), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
